// File: rtl/serial_cla_add32_pkg.sv
// Shared definitions for the iterative nibble-serial CLA adder/subtractor.
package serial_cla_add32_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned NIBBLE = 4;

endpackage

// File: rtl/serial_cla_add32_if.sv
// Start/done request bus between the control unit and the serial adder.
interface serial_cla_add32_if #(
    parameter int unsigned WIDTH = 32
);
    logic             i_start;
    logic             i_sub;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_result;
    logic             o_cout;
    logic             o_overflow;

    modport master (
        output i_start, i_sub, i_a, i_b,
        input  o_busy, o_done, o_result, o_cout, o_overflow
    );

    modport slave (
        input  i_start, i_sub, i_a, i_b,
        output o_busy, o_done, o_result, o_cout, o_overflow
    );
endinterface

// File: rtl/serial_cla_add32_cla.sv
// 4-bit carry-lookahead slice: all carries are derived directly from g/p and carry-in.
module CLA_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    assign c[0] = c_i;
    assign c[1] = g[0] | (p[0] & c_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_i);
    assign c_o  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c_i);

    assign s_o = p ^ c;
endmodule

// File: rtl/serial_cla_add32.sv
// Iterative WIDTH-bit add/sub: one shared CLA_4bit slice consumes one nibble per clock, LSB first.
module serial_cla_add32
    import serial_cla_add32_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic              clk,
    input logic              rst,
    serial_cla_add32_if.slave bus
);
    localparam int unsigned NNIB = WIDTH / NIBBLE;
    localparam int unsigned CW   = $clog2(NNIB);
    localparam logic [CW-1:0] LAST = CW'(NNIB - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic             load;
    logic [WIDTH-1:0] b_eff;
    logic [3:0]       slice_sum;
    logic             slice_cout;

    CLA_4bit u_cla (
        .a_i (a_q[NIBBLE-1:0]),
        .b_i (b_q[NIBBLE-1:0]),
        .c_i (carry_q),
        .s_o (slice_sum),
        .c_o (slice_cout)
    );

    // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
    assign b_eff = bus.i_sub ? ~bus.i_b : bus.i_b;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        amsb_d   = amsb_q;
        bmsb_d   = bmsb_q;
        load     = 1'b0;

        case (state_q)
            IDLE: load = bus.i_start;
            RUN: begin
                a_d      = a_q >> NIBBLE;
                b_d      = b_q >> NIBBLE;
                result_d = {slice_sum, result_q[WIDTH-1:NIBBLE]};
                carry_d  = slice_cout;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                load = bus.i_start;
                if (!bus.i_start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d  = RUN;
            a_d      = bus.i_a;
            b_d      = b_eff;
            carry_d  = bus.i_sub;
            cnt_d    = '0;
            result_d = '0;
            amsb_d   = bus.i_a[WIDTH-1];
            bmsb_d   = b_eff[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            amsb_q   <= 1'b0;
            bmsb_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            amsb_q   <= amsb_d;
            bmsb_q   <= bmsb_d;
        end
    end

    assign bus.o_busy     = (state_q == RUN);
    assign bus.o_done     = (state_q == DONE);
    assign bus.o_result   = result_q;
    assign bus.o_cout     = carry_q;
    assign bus.o_overflow = (amsb_q == bmsb_q) && (result_q[WIDTH-1] != amsb_q);
endmodule

// File: tb/tb_serial_cla_add32.sv
// Scoreboard bench for serial_cla_add32: expected results queued at start, checked on done.
module tb_serial_cla_add32;
    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_cla_add32_if #(.WIDTH(W)) bus ();

    serial_cla_add32 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t         sb[$];
    int unsigned  total = 0;
    int unsigned  bad = 0;
    logic [W-1:0] last_res = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t       m;
        logic [W-1:0] bp;
        logic [W:0]   s;
        bp     = sub ? ~b : b;
        s      = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, sub};
        m.res  = s[W-1:0];
        m.cout = s[W];
        m.ovf  = (a[W-1] == bp[W-1]) && (s[W-1] != a[W-1]);
        return m;
    endfunction

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_sub   = sub;
        bus.i_start = 1'b1;
        sb.push_back(model(a, b, sub));
    endtask

    // Entered at the negedge right after the accept edge.
    task automatic wait_check(input string tag, input int exp_lat);
        int   lat = 0;
        int   busy_n = bus.o_busy ? 1 : 0;
        exp_t e;
        while (!bus.o_done && lat < 30) begin
            @(negedge clk);
            lat++;
            if (bus.o_busy) busy_n++;
        end
        check({tag, "_done_seen"}, 64'(bus.o_done), 64'(1));
        if (!bus.o_done) return;
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 64'(0), 64'(1));
            return;
        end
        e = sb.pop_front();
        last_res = e.res;
        check({tag, "_result"}, 64'(bus.o_result), 64'(e.res));
        check({tag, "_cout"}, 64'(bus.o_cout), 64'(e.cout));
        check({tag, "_ovf"}, 64'(bus.o_overflow), 64'(e.ovf));
        if (exp_lat >= 0) begin
            check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
            check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat));
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input bit chk_hold);
        start_op(a, b, sub);
        @(negedge clk);
        bus.i_start = 1'b0;
        wait_check(tag, 8);
        if (chk_hold) begin
            @(negedge clk);
            check({tag, "_done_pulse"}, 64'(bus.o_done), 64'(0));
            check({tag, "_held"}, 64'(bus.o_result), 64'(last_res));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 64'(bus.o_busy), 64'(0));
        check({tag, "_done"}, 64'(bus.o_done), 64'(0));
        check({tag, "_result"}, 64'(bus.o_result), 64'(0));
        check({tag, "_cout"}, 64'(bus.o_cout), 64'(0));
        check({tag, "_ovf"}, 64'(bus.o_overflow), 64'(0));
    endtask

    logic [W-1:0] b2b_a[4] = '{32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0010};
    logic [W-1:0] b2b_b[4] = '{32'h0FED_CBA9, 32'h0000_0001, 32'h0000_0001, 32'h0000_0020};
    logic         b2b_s[4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        bit saw_done;
        rst         = 1'b1;
        bus.i_start = 1'b0;
        bus.i_sub   = 1'b0;
        bus.i_a     = '0;
        bus.i_b     = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        run_op("add_carry16", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        run_op("sub_5m7",     32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
        run_op("sub_7m5",     32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0);
        run_op("add_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        run_op("add_wrap",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op("sub_negovf",  32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
        @(negedge clk);

        // Start held high: each new op accepted on the DONE cycle of the previous.
        start_op(b2b_a[0], b2b_b[0], b2b_s[0]);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i < 3) start_op(b2b_a[i+1], b2b_b[i+1], b2b_s[i+1]);
            else bus.i_start = 1'b0;
            wait_check("b2b", 8);
        end
        @(negedge clk);

        // Start pulsed mid-RUN must be ignored and not queued.
        start_op(32'h1234_5678, 32'h1111_1111, 1'b0);
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (2) @(negedge clk);
        bus.i_a     = 32'hDEAD_BEEF;
        bus.i_b     = 32'h0BAD_F00D;
        bus.i_sub   = 1'b1;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        wait_check("ignored_start", -1);
        @(negedge clk);
        check("ignored_not_queued_busy", 64'(bus.o_busy), 64'(0));
        @(negedge clk);
        check("ignored_not_queued_busy2", 64'(bus.o_busy), 64'(0));

        // Reset in the 4th RUN cycle discards the operation.
        start_op(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        void'(sb.pop_back());
        check_zero("midrun_reset");
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.o_done) saw_done = 1'b1;
        end
        check("midrun_no_done", 64'(saw_done), 64'(0));
        run_op("after_reset_3p4", 32'd3, 32'd4, 1'b0, 1'b1);

        for (int i = 0; i < 150; i++) begin
            run_op("rand", W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_cla_add32.md
# serial_cla_add32

Iterative wide adder/subtractor that sequences a single 4-bit carry-lookahead slice over a WIDTH-bit operand pair, one nibble per clock, least-significant first. It sits beside the ALU as a low-area add/sub unit. It trades latency (WIDTH/4 cycles) for reuse of one CLA slice, and is driven by the control unit through a start/done handshake.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of 4 and ≥ 8.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  request; sampled only in IDLE or DONE.
- i_sub  in  1  0 = A+B, 1 = A−B; latched with operands.
- i_a  in  WIDTH  operand A; latched on accepted start.
- i_b  in  WIDTH  operand B; latched on accepted start.
- o_busy  out  1  high while in RUN.
- o_done  out  1  one-cycle pulse; result valid.
- o_result  out  WIDTH  sum/difference; held until next accepted start.
- o_cout  out  1  carry out of MSB (for subtract: 1 = no borrow).
- o_overflow  out  1  two's-complement signed overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, i_start=1: latch A, (i_sub ? ~B : B), i_sub, and carry register = i_sub. Clear nibble counter and result register, then go to RUN.
- IDLE, i_start=0: stay in IDLE.
- RUN, each edge: the slice adds A[3:0] + B'[3:0] + carry.
  - Slice sum shifts into o_result from the top.
  - A and B' shift right by 4.
  - Carry register takes the slice cout.
  - Counter increments.
  - On the edge where counter = WIDTH/4−1, go to DONE.
- DONE: o_done=1 for exactly this cycle. o_result, o_cout and o_overflow are valid and remain stable until the next accepted start.
  - i_start=1 in DONE: accepted immediately (back-to-back); load as from IDLE and go to RUN.
  - i_start=0 in DONE: go to IDLE.
- i_start in RUN is ignored; the request is not queued.
- o_cout = carry register after the final nibble.
- Overflow uses the latched operand sign bits, captured at start, and the final result MSB: o_overflow = (a_msb == b'_msb) && (result_msb != a_msb), where b' is the possibly inverted B.
- Reset (any state, including mid-RUN): state=IDLE, counter=0, carry=0, operand registers=0. Reset values of outputs: o_busy=0, o_done=0, o_result=0, o_cout=0, o_overflow=0. An in-flight operation is discarded with no done pulse.
- Arithmetic is modulo 2^WIDTH; no saturation.

## Timing
- Start accepted at edge E0. RUN spans edges E1..E(WIDTH/4); for WIDTH=32 that is E1..E8.
- o_done is high between E(WIDTH/4) and E(WIDTH/4)+1, i.e. a latency of WIDTH/4 cycles from the accept edge.
- o_busy is high from after E0 until after E(WIDTH/4).
- Throughput with back-to-back starts: one result per WIDTH/4+1 cycles.
- The slice path is combinational inside one cycle: register → CLA → register. No combinational path from inputs to outputs.
- i_a, i_b and i_sub may change freely after the accept edge.

## Structure
- Shared package: the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the constant NIBBLE=4.
- Sub-module: one instance of CLA_4bit, the team's 4-bit carry-lookahead slice.
  - Inputs: low nibble of the A shift register, low nibble of the B' shift register, and the carry register.
  - Outputs: the 4-bit sum and cout, feeding the shift/carry registers.
- Counter width: $clog2(WIDTH/4).

## Test plan
- Add 0x0000_FFFF + 0x0000_0001, i_sub=0 → done 8 cycles after start; result 0x0001_0000, cout=0, overflow=0; busy high for exactly 8 cycles.
- Subtract 0x0000_0005 − 0x0000_0007 → result 0xFFFF_FFFE, cout=0, overflow=0. Subtract 7 − 5 → result 0x0000_0002, cout=1.
- Add 0x7FFF_FFFF + 0x0000_0001 → result 0x8000_0000, overflow=1. Add 0xFFFF_FFFF + 0x0000_0001 → result 0, cout=1, overflow=0.
- Start held high continuously with new operands each op → back-to-back results every 9 cycles, each correct. Starts pulsed during RUN → ignored; result unaffected.
- Assert rst at RUN cycle 4 → next cycle all outputs 0, state IDLE, no done pulse. A fresh add 3+4 then yields 7 after 8 cycles.
- Random regression of 10k operand pairs with random i_sub against a reference model, including WIDTH=8 and WIDTH=64 builds → all results, cout and overflow match.
